ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
Execute-to-memory pipeline stage of the 16-bit CPU, directly downstream of the ALU. Each cycle it latches the ALU result and carry, updates the architectural flag register (zf, nf, cf), resolves branches and jumps, and presents a registered instruction to the memory/writeback stage. The cf output feeds back to the ALU carry-in for ADDC/SUBC. It also provides a forwarding path and squashes wrong-path instructions after a taken branch. Opcodes use the shared `config.v` macros.

Parameters:
FLUSH_SLOTS, 2, number of valid instructions accepted after a taken branch/jump that are squashed (1..7).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
ex_valid  in  1  EX holds a valid instruction
ex_ir  in  5  opcode of EX instruction
ex_rd  in  3  destination register index
ex_alu  in  16  ALU result (ALUo)
ex_cf  in  1  ALU carry/borrow out
ex_store_data  in  16  register data for STORE
mem_stall  in  1  MEM stage cannot accept
ex_ready  out  1  equals !mem_stall; the stage accepts when ex_valid & ex_ready
mem_valid  out  1  registered instruction valid
mem_ir  out  5  registered opcode
mem_rd  out  3  registered destination
mem_result  out  16  registered ALU result / address
mem_store_data  out  16  registered store data
mem_we  out  1  register writeback enable
mem_rd_en  out  1  data-memory read (LOAD)
mem_wr_en  out  1  data-memory write (STORE)
zf, nf, cf  out  1 each  flag register
br_taken  out  1  one-cycle pulse: redirect fetch
br_target  out  16  redirect address, valid with br_taken
fwd_valid  out  1  mem_valid & mem_we & !mem_rd_en
fwd_rd  out  3  equals mem_rd
fwd_data  out  16  equals mem_result

Behaviour:
- Reset: every registered output and the flags are 0, squash counter is 0 (state RUN), and br_target is 16'h0000.
- Accept edge: ex_valid & !mem_stall. Latency is 1 cycle: mem_* and flags reflect the accepted instruction after that edge.
- Stall (mem_stall=1):
  - All mem_*, flags, counter and br_target hold their values.
  - ex_valid is ignored.
  - br_taken still deasserts after its single cycle.
- No accept and no stall: mem_valid <= 0, other mem_* hold, flags hold.
- Flag classes, zf = (ex_alu==0), nf = ex_alu[15]:
  - ADD, ADDI, ADDC, SUB, SUBI, SUBC, CMP: update zf, nf, and cf <= ex_cf.
  - AND, OR, XOR, SLL, SRL, SLA, SRA: update zf and nf; cf is unchanged.
  - All other opcodes: flags are unchanged.
- Enables (set on accept, non-squashed):
  - mem_we = 1 for the arithmetic/logic classes except CMP, and for LDIH and LOAD.
  - mem_rd_en = 1 for LOAD only.
  - mem_wr_en = 1 for STORE only.
  - JUMP, branches, CMP and unknown opcodes: mem_valid=1 with all three enables 0.
- Branch resolution uses flag values before the edge (flags set by the previous accepted instruction):
  - JUMP is always taken.
  - ir[4:3]==2'b11 selects the condition from ir[2:0]: 000 always, 001 zf, 010 !zf, 011 nf, 100 !nf, 101 cf, 110 !cf, 111 never.
  - Taken: br_taken=1 for exactly the cycle after the accept edge, and br_target <= ex_alu.
  - Not taken: no pulse.
- Squash FSM, states RUN and SQUASH:
  - A taken branch accepted in RUN loads the counter with FLUSH_SLOTS and moves to SQUASH.
  - In SQUASH, each accepted instruction decrements the counter and is dropped: mem_valid <= 0, no flag update, no branch evaluation. A branch being squashed is never taken.
  - The state returns to RUN when the counter reaches 0.
  - Stall cycles do not decrement the counter.
- Synchronous reset at any time, including mid-squash or during stall, overrides everything: RUN, counter 0, outputs 0.
- Widths: no arithmetic is performed; ex_alu passes through unmodified.

Test Plan:
1. Assert reset for 2 cycles with random inputs -> all outputs 0, zf=nf=cf=0, ex_ready=!mem_stall.
2. Accept ADD with ex_alu=16'h0000, ex_cf=1, ex_rd=3 -> next cycle mem_valid=1, mem_we=1, mem_result=0, zf=1, nf=0, cf=1, fwd_valid=1, fwd_rd=3. Then accept AND with ex_alu=16'h8000 -> zf=0, nf=1, cf stays 1.
3. Accept CMP with ex_alu=16'h0005, ex_cf=0 -> mem_we=0, zf=0, nf=0, cf=0. Accept LOAD with ex_alu=16'h0010 -> mem_rd_en=1, mem_we=1, fwd_valid=0, flags unchanged.
4. With zf=1, accept BZ (ir[4:3]=11, ir[2:0]=001) with ex_alu=16'h0040 -> br_taken is a 1-cycle pulse, br_target=16'h0040. The next 2 accepted ADDs give mem_valid=0 with flags unchanged; the 3rd ADD passes. BNZ in the same state -> no pulse.
5. Hold mem_stall=1 for 3 cycles with SUB presented -> ex_ready=0 and all outputs/flags hold. Release -> SUB is accepted on the next edge.
6. Assert reset one cycle after a taken JUMP (mid-squash) -> state RUN. The next ADD passes with mem_valid=1.

Source files
------------

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline register: latches ALU results, maintains the zf/nf/cf flags,
// resolves branches and jumps, and squashes the wrong-path instructions that follow a taken one.

package ex_mem_pkg;
   // Opcode encodings; the values match the shared config.v macros.
   localparam logic [4:0] OP_ADD   = 5'h00;
   localparam logic [4:0] OP_ADDI  = 5'h01;
   localparam logic [4:0] OP_ADDC  = 5'h02;
   localparam logic [4:0] OP_SUB   = 5'h03;
   localparam logic [4:0] OP_SUBI  = 5'h04;
   localparam logic [4:0] OP_SUBC  = 5'h05;
   localparam logic [4:0] OP_CMP   = 5'h06;
   localparam logic [4:0] OP_AND   = 5'h07;
   localparam logic [4:0] OP_OR    = 5'h08;
   localparam logic [4:0] OP_XOR   = 5'h09;
   localparam logic [4:0] OP_SLL   = 5'h0A;
   localparam logic [4:0] OP_SRL   = 5'h0B;
   localparam logic [4:0] OP_SLA   = 5'h0C;
   localparam logic [4:0] OP_SRA   = 5'h0D;
   localparam logic [4:0] OP_LDIH  = 5'h0E;
   localparam logic [4:0] OP_LOAD  = 5'h0F;
   localparam logic [4:0] OP_STORE = 5'h10;
   localparam logic [4:0] OP_JUMP  = 5'h11;
   localparam logic [4:0] OP_NOP   = 5'h12;
   // Conditional branches occupy ir[4:3] == 2'b11; ir[2:0] selects the condition.
   localparam logic [4:0] OP_BAL   = 5'h18;
   localparam logic [4:0] OP_BZ    = 5'h19;
   localparam logic [4:0] OP_BNZ   = 5'h1A;
   localparam logic [4:0] OP_BN    = 5'h1B;
   localparam logic [4:0] OP_BNN   = 5'h1C;
   localparam logic [4:0] OP_BC    = 5'h1D;
   localparam logic [4:0] OP_BNC   = 5'h1E;
   localparam logic [4:0] OP_BNV   = 5'h1F;
endpackage

module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int unsigned FLUSH_SLOTS = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [4:0]  ex_ir,
   input  logic [2:0]  ex_rd,
   input  logic [15:0] ex_alu,
   input  logic        ex_cf,
   input  logic [15:0] ex_store_data,
   input  logic        mem_stall,
   output logic        ex_ready,
   output logic        mem_valid,
   output logic [4:0]  mem_ir,
   output logic [2:0]  mem_rd,
   output logic [15:0] mem_result,
   output logic [15:0] mem_store_data,
   output logic        mem_we,
   output logic        mem_rd_en,
   output logic        mem_wr_en,
   output logic        zf,
   output logic        nf,
   output logic        cf,
   output logic        br_taken,
   output logic [15:0] br_target,
   output logic        fwd_valid,
   output logic [2:0]  fwd_rd,
   output logic [15:0] fwd_data
);

   typedef enum logic {RUN, SQUASH} state_e;

   localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_SLOTS);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        mem_valid_q, mem_valid_d;
   logic [4:0]  mem_ir_q, mem_ir_d;
   logic [2:0]  mem_rd_q, mem_rd_d;
   logic [15:0] mem_result_q, mem_result_d;
   logic [15:0] mem_store_data_q, mem_store_data_d;
   logic        mem_we_q, mem_we_d;
   logic        mem_rd_en_q, mem_rd_en_d;
   logic        mem_wr_en_q, mem_wr_en_d;
   logic        zf_q, zf_d;
   logic        nf_q, nf_d;
   logic        cf_q, cf_d;
   logic        br_taken_q, br_taken_d;
   logic [15:0] br_target_q, br_target_d;

   logic is_arith, is_logic, writes_reg, cond_met, taken;

   // Instruction decode: flag class, writeback enable, branch condition.
   always_comb begin
      is_arith   = ex_ir inside {OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP};
      is_logic   = ex_ir inside {OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA};
      writes_reg = (is_arith && ex_ir != OP_CMP) || is_logic || ex_ir == OP_LDIH || ex_ir == OP_LOAD;
      unique case (ex_ir[2:0])
         3'b000:  cond_met = 1'b1;
         3'b001:  cond_met = zf_q;
         3'b010:  cond_met = !zf_q;
         3'b011:  cond_met = nf_q;
         3'b100:  cond_met = !nf_q;
         3'b101:  cond_met = cf_q;
         3'b110:  cond_met = !cf_q;
         default: cond_met = 1'b0;
      endcase
      // Conditions read the flags as they stand before this edge, never the ones being written.
      taken = (ex_ir == OP_JUMP) || (ex_ir[4:3] == 2'b11 && cond_met);
   end

   always_comb begin
      // NOTE: every signal gets a hold value first so no path leaves it unassigned (no latches).
      state_d          = state_q;
      cnt_d            = cnt_q;
      mem_valid_d      = mem_valid_q;
      mem_ir_d         = mem_ir_q;
      mem_rd_d         = mem_rd_q;
      mem_result_d     = mem_result_q;
      mem_store_data_d = mem_store_data_q;
      mem_we_d         = mem_we_q;
      mem_rd_en_d      = mem_rd_en_q;
      mem_wr_en_d      = mem_wr_en_q;
      zf_d             = zf_q;
      nf_d             = nf_q;
      cf_d             = cf_q;
      br_taken_d       = 1'b0;
      br_target_d      = br_target_q;

      if (!mem_stall) begin
         mem_valid_d = 1'b0;
         if (ex_valid) begin
            if (state_q == SQUASH) begin
               cnt_d = cnt_q - 3'd1;
               if (cnt_q == 3'd1) state_d = RUN;
            end else begin
               mem_valid_d      = 1'b1;
               mem_ir_d         = ex_ir;
               mem_rd_d         = ex_rd;
               mem_result_d     = ex_alu;
               mem_store_data_d = ex_store_data;
               mem_we_d         = writes_reg;
               mem_rd_en_d      = (ex_ir == OP_LOAD);
               mem_wr_en_d      = (ex_ir == OP_STORE);
               if (is_arith || is_logic) begin
                  zf_d = (ex_alu == 16'h0000);
                  nf_d = ex_alu[15];
               end
               if (is_arith) cf_d = ex_cf;
               if (taken) begin
                  br_taken_d  = 1'b1;
                  br_target_d = ex_alu;
                  cnt_d       = FLUSH_CNT;
                  state_d     = SQUASH;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         state_q          <= RUN;
         cnt_q            <= '0;
         mem_valid_q      <= 1'b0;
         mem_ir_q         <= '0;
         mem_rd_q         <= '0;
         mem_result_q     <= '0;
         mem_store_data_q <= '0;
         mem_we_q         <= 1'b0;
         mem_rd_en_q      <= 1'b0;
         mem_wr_en_q      <= 1'b0;
         zf_q             <= 1'b0;
         nf_q             <= 1'b0;
         cf_q             <= 1'b0;
         br_taken_q       <= 1'b0;
         br_target_q      <= '0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         mem_valid_q      <= mem_valid_d;
         mem_ir_q         <= mem_ir_d;
         mem_rd_q         <= mem_rd_d;
         mem_result_q     <= mem_result_d;
         mem_store_data_q <= mem_store_data_d;
         mem_we_q         <= mem_we_d;
         mem_rd_en_q      <= mem_rd_en_d;
         mem_wr_en_q      <= mem_wr_en_d;
         zf_q             <= zf_d;
         nf_q             <= nf_d;
         cf_q             <= cf_d;
         br_taken_q       <= br_taken_d;
         br_target_q      <= br_target_d;
      end
   end

   assign ex_ready       = !mem_stall;
   assign mem_valid      = mem_valid_q;
   assign mem_ir         = mem_ir_q;
   assign mem_rd         = mem_rd_q;
   assign mem_result     = mem_result_q;
   assign mem_store_data = mem_store_data_q;
   assign mem_we         = mem_we_q;
   assign mem_rd_en      = mem_rd_en_q;
   assign mem_wr_en      = mem_wr_en_q;
   assign zf             = zf_q;
   assign nf             = nf_q;
   assign cf             = cf_q;
   assign br_taken       = br_taken_q;
   assign br_target      = br_target_q;
   // Loads produce their value only after memory, so they cannot forward from here.
   assign fwd_valid      = mem_valid_q & mem_we_q & !mem_rd_en_q;
   assign fwd_rd         = mem_rd_q;
   assign fwd_data       = mem_result_q;

endmodule
